// File: rtl/usb_rx_pkg.sv
// Shared USB receive-path types and line constants.
// Full-speed USB values are used as the deserialiser parameter defaults.
package usb_rx_pkg;

    localparam int   USB_STUFF_LEN = 6;
    localparam logic USB_LINE_J    = 1'b1;
    localparam int   USB_BYTE_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } rx_deser_state_t;

endpackage

// File: rtl/rx_word_shift.sv
// Deserialising shift register with bit counter.
// Publishes each completed word on o_word with a one-cycle o_word_done strobe.
module rx_word_shift
    import usb_rx_pkg::*;
#(
    parameter int WORD_W    = USB_BYTE_W,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              i_shift,
    input  logic              i_bit,
    input  logic              i_clear,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_done
);

    localparam int            CW   = $clog2(WORD_W);
    localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);

    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] w_next;
    logic [CW-1:0]     r_bit_cnt;
    logic [WORD_W-1:0] r_word;
    logic              r_word_done;

    // LSB-first fills from the top so the first bit ends up at bit 0.
    generate
        if (LSB_FIRST) begin : g_lsb
            assign w_next = {i_bit, r_shift[WORD_W-1:1]};
        end else begin : g_msb
            assign w_next = {r_shift[WORD_W-2:0], i_bit};
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_word      <= '0;
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= 1'b0;
            if (i_clear) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end else if (i_shift) begin
                r_shift <= w_next;
                if (r_bit_cnt == LAST) begin
                    r_bit_cnt   <= '0;
                    r_word      <= w_next;
                    r_word_done <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                end
            end
        end
    end

    assign o_word      = r_word;
    assign o_word_done = r_word_done;

endmodule

// File: rtl/rx_nrzi_deser.sv
// USB receive front end: NRZI decode, bit unstuffing with stuff-error detection,
// and deserialisation into WORD_W-bit words.
module rx_nrzi_deser
    import usb_rx_pkg::*;
#(
    parameter int   WORD_W     = USB_BYTE_W,
    parameter int   STUFF_LEN  = USB_STUFF_LEN,
    parameter logic IDLE_LEVEL = USB_LINE_J,
    parameter bit   LSB_FIRST  = 1'b1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              shift_en,
    input  logic              dplus_sync,
    input  logic              rcving,
    output logic              d_orig,
    output logic              bit_valid,
    output logic [WORD_W-1:0] data_out,
    output logic              word_valid,
    output logic              stuff_err,
    output logic [1:0]        o_dbg_state
);

    localparam int            OW       = $clog2(STUFF_LEN + 1);
    localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LEN);

    rx_deser_state_t r_state;
    rx_deser_state_t w_state_nxt;

    logic          r_prev;
    logic [OW-1:0] r_ones;
    logic          r_d_orig;
    logic          r_bit_valid;
    logic          r_stuff_err;

    logic w_take;
    logic w_dec;
    logic w_at_max;
    logic w_data;
    logic w_stuff;
    logic w_viol;

    // ERR freezes the bit stream until the packet ends.
    assign w_take   = shift_en & rcving & (r_state != ERR);
    assign w_dec    = ~(dplus_sync ^ r_prev);
    assign w_at_max = (r_ones == ONES_MAX);
    assign w_data   = w_take & ~w_at_max;
    assign w_stuff  = w_take & w_at_max & ~w_dec;
    assign w_viol   = w_take & w_at_max & w_dec;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (rcving) w_state_nxt = RUN;
            RUN: begin
                if (!rcving) begin
                    w_state_nxt = IDLE;
                end else if (w_viol) begin
                    w_state_nxt = ERR;
                end
            end
            ERR: if (!rcving) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Line history and the ones run restart at every packet boundary.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_prev      <= IDLE_LEVEL;
            r_ones      <= '0;
            r_d_orig    <= 1'b0;
            r_bit_valid <= 1'b0;
            r_stuff_err <= 1'b0;
        end else if (!rcving) begin
            r_prev      <= IDLE_LEVEL;
            r_ones      <= '0;
            r_bit_valid <= 1'b0;
            r_stuff_err <= 1'b0;
        end else begin
            r_bit_valid <= w_data;
            if (w_take) begin
                r_prev <= dplus_sync;
            end
            if (w_data) begin
                r_d_orig <= w_dec;
                r_ones   <= w_dec ? (r_ones + OW'(1)) : '0;
            end
            if (w_stuff) begin
                r_ones <= '0;
            end
            if (w_viol) begin
                r_stuff_err <= 1'b1;
            end
        end
    end

    rx_word_shift #(
        .WORD_W   (WORD_W),
        .LSB_FIRST(LSB_FIRST)
    ) u_word_shift (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_shift    (w_data),
        .i_bit      (w_dec),
        .i_clear    (~rcving),
        .o_word     (data_out),
        .o_word_done(word_valid)
    );

    assign d_orig      = r_d_orig;
    assign bit_valid   = r_bit_valid;
    assign stuff_err   = r_stuff_err;
    assign o_dbg_state = r_state;

endmodule
